// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: control-op encodings
// and the interrupt vector address helper.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_HOLD   = 3'd1,
    OP_JUMP   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5,
    OP_RETI   = 3'd6,
    OP_FLUSH  = 3'd7
  } op_e;

  // Computed at full 64-bit width; callers truncate to their address width,
  // which gives the modulo-2^ADDR_W behaviour for free.
  function automatic logic [63:0] vector_addr(input int unsigned idx,
                                              input logic [63:0] base,
                                              input logic [63:0] stride);
    return base + 64'(idx) * stride;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch-side bundle of the program-counter sequencer.
// The master is the decode/control unit; the slave is the sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_IRQ = 4,
  parameter int DEPTH_W = 4
);
  import pc_pkg::*;

  logic               start;
  op_e                op;
  logic [ADDR_W-1:0]  target;
  logic               fetch_complete;
  logic [NUM_IRQ-1:0] irq;
  logic               irq_enable;

  logic [ADDR_W-1:0]  pc;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               in_isr;
  logic [DEPTH_W-1:0] call_depth;
  logic [DEPTH_W-1:0] isr_depth;
  logic               stack_overflow;
  logic               stack_underflow;

  modport master (
    output start, op, target, fetch_complete, irq, irq_enable,
    input  pc, irq_ack, in_isr, call_depth, isr_depth,
           stack_overflow, stack_underflow
  );

  modport slave (
    input  start, op, target, fetch_complete, irq, irq_enable,
    output pc, irq_ack, in_isr, call_depth, isr_depth,
           stack_overflow, stack_underflow
  );

endinterface

// File: rtl/return_stack.sv
// LIFO of return addresses. Push on full and pop on empty are ignored; the
// caller owns fault reporting. A synchronous clear empties the stack.
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_m1;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign depth    = count;
  assign count_m1 = count - CW'(1);
  assign dout     = mem[count_m1[AW-1:0]];

  // NOTE: the storage array has no reset; only the occupancy counter does, so
  // the array maps onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[count[AW-1:0]] <= din;
    end
  end

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised interrupt entry, control-op next-pc
// selection, separate call/ISR return stacks and sticky stack-fault flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                STACK_DEPTH = 8,
  parameter int                NUM_IRQ     = 4,
  parameter logic [ADDR_W-1:0] VEC_BASE    = 'h80,
  parameter logic [ADDR_W-1:0] VEC_STRIDE  = 'h80,
  localparam int               DEPTH_W     = $clog2(STACK_DEPTH) + 1,
  localparam int               IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  logic [ADDR_W-1:0]  pc_q;
  logic [NUM_IRQ-1:0] ack_q;
  logic               ovf_q;
  logic               udf_q;

  logic [ADDR_W-1:0]  call_top;
  logic [ADDR_W-1:0]  isr_top;
  logic [DEPTH_W-1:0] call_cnt;
  logic [DEPTH_W-1:0] isr_cnt;
  logic               call_full, call_empty;
  logic               isr_full, isr_empty;

  logic [NUM_IRQ-1:0] eligible;
  logic               take_irq;
  logic [IDX_W-1:0]   irq_idx;
  logic [ADDR_W-1:0]  vec_pc;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  ret_addr;

  logic [ADDR_W-1:0]  pc_next;
  logic [NUM_IRQ-1:0] ack_next;
  logic               call_push, call_pop;
  logic               isr_push, isr_pop;
  logic               set_ovf, set_udf;

  // Line 0 is non-maskable and nests; the others need the global enable and
  // an idle ISR stack.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (i == 0) eligible[i] = bus.irq[i];
      else        eligible[i] = bus.irq[i] && bus.irq_enable && isr_empty;
    end
  end

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    take_irq = 1'b0;
    irq_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        take_irq = 1'b1;
        irq_idx  = IDX_W'(i);
      end
    end
  end

  assign vec_pc   = ADDR_W'(vector_addr(32'(irq_idx), 64'(VEC_BASE), 64'(VEC_STRIDE)));
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign ret_addr = bus.fetch_complete ? pc_inc : pc_q;

  always_comb begin
    pc_next   = pc_q;
    ack_next  = '0;
    call_push = 1'b0;
    call_pop  = 1'b0;
    isr_push  = 1'b0;
    isr_pop   = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;

    if (bus.start) begin
      pc_next = '0;
    end else if (take_irq) begin
      isr_push          = 1'b1;
      set_ovf           = isr_full;
      pc_next           = vec_pc;
      ack_next[irq_idx] = 1'b1;
    end else begin
      unique case (bus.op)
        OP_NEXT:   if (bus.fetch_complete) pc_next = pc_inc;
        OP_HOLD:   pc_next = pc_q;
        OP_JUMP:   pc_next = bus.target;
        OP_BRANCH: pc_next = pc_q + bus.target;
        OP_CALL: begin
          call_push = 1'b1;
          set_ovf   = call_full;
          pc_next   = bus.target;
        end
        OP_RET: begin
          if (call_empty) set_udf = 1'b1;
          else begin
            call_pop = 1'b1;
            pc_next  = call_top;
          end
        end
        OP_RETI: begin
          if (isr_empty) set_udf = 1'b1;
          else begin
            isr_pop = 1'b1;
            pc_next = isr_top;
          end
        end
        OP_FLUSH:  pc_next = '0;
        default:   pc_next = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      ack_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.start) begin
      pc_q  <= '0;
      ack_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      ack_q <= ack_next;
      ovf_q <= ovf_q | set_ovf;
      udf_q <= udf_q | set_udf;
    end
  end

  return_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_call_stack (
    .clk   (clk),
    .reset (reset),
    .clear (bus.start),
    .push  (call_push),
    .pop   (call_pop),
    .din   (pc_inc),
    .dout  (call_top),
    .depth (call_cnt),
    .full  (call_full),
    .empty (call_empty)
  );

  return_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_isr_stack (
    .clk   (clk),
    .reset (reset),
    .clear (bus.start),
    .push  (isr_push),
    .pop   (isr_pop),
    .din   (ret_addr),
    .dout  (isr_top),
    .depth (isr_cnt),
    .full  (isr_full),
    .empty (isr_empty)
  );

  assign bus.pc              = pc_q;
  assign bus.irq_ack         = ack_q;
  assign bus.in_isr          = !isr_empty;
  assign bus.call_depth      = call_cnt;
  assign bus.isr_depth       = isr_cnt;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = udf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
  import pc_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int NUM_IRQ = 4;
  localparam int DEPTH_W = 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .NUM_IRQ(NUM_IRQ), .DEPTH_W(DEPTH_W)) bus ();

  pc_sequencer #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (8),
    .NUM_IRQ     (NUM_IRQ),
    .VEC_BASE    (32'h80),
    .VEC_STRIDE  (32'h80)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pc"},         64'(bus.pc), 64'h0);
    check({tag, " irq_ack"},    64'(bus.irq_ack), 64'h0);
    check({tag, " in_isr"},     64'(bus.in_isr), 64'h0);
    check({tag, " call_depth"}, 64'(bus.call_depth), 64'h0);
    check({tag, " isr_depth"},  64'(bus.isr_depth), 64'h0);
    check({tag, " overflow"},   64'(bus.stack_overflow), 64'h0);
    check({tag, " underflow"},  64'(bus.stack_underflow), 64'h0);
  endtask

  initial begin
    tests_run          = 0;
    tests_failed       = 0;
    reset              = 1'b1;
    bus.start          = 1'b0;
    bus.op             = OP_HOLD;
    bus.target         = '0;
    bus.fetch_complete = 1'b0;
    bus.irq            = '0;
    bus.irq_enable     = 1'b0;
    #1;
    check_reset_state("reset");
    #12 reset = 1'b0;

    // start, then sequential fetch
    bus.start = 1'b1;
    step();
    check("start pc", 64'(bus.pc), 64'h0);
    bus.start          = 1'b0;
    bus.op             = OP_NEXT;
    bus.fetch_complete = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("next pc", 64'(bus.pc), 64'(i));
    end
    bus.fetch_complete = 1'b0;
    step();
    check("next stall pc", 64'(bus.pc), 64'h3);
    bus.fetch_complete = 1'b1;

    // call / return
    bus.op = OP_JUMP; bus.target = 32'h10;
    step();
    check("jump pc", 64'(bus.pc), 64'h10);
    bus.op = OP_CALL; bus.target = 32'h400;
    step();
    check("call pc", 64'(bus.pc), 64'h400);
    check("call depth", 64'(bus.call_depth), 64'h1);
    bus.op = OP_RET;
    step();
    check("ret pc", 64'(bus.pc), 64'h11);
    check("ret depth", 64'(bus.call_depth), 64'h0);

    // maskable interrupt, nested NMI, two RETIs
    bus.op = OP_JUMP; bus.target = 32'h20;
    step();
    bus.op = OP_HOLD; bus.irq = 4'b0110; bus.irq_enable = 1'b1;
    step();
    check("irq1 pc", 64'(bus.pc), 64'h100);
    check("irq1 ack", 64'(bus.irq_ack), 64'h2);
    check("irq1 in_isr", 64'(bus.in_isr), 64'h1);
    bus.irq = 4'b0001;
    step();
    check("nmi pc", 64'(bus.pc), 64'h80);
    check("nmi ack", 64'(bus.irq_ack), 64'h1);
    check("nmi isr_depth", 64'(bus.isr_depth), 64'h2);
    bus.irq = 4'b0000; bus.op = OP_RETI;
    step();
    check("reti1 pc", 64'(bus.pc), 64'h101);
    check("reti1 ack", 64'(bus.irq_ack), 64'h0);
    step();
    check("reti2 pc", 64'(bus.pc), 64'h21);
    check("reti2 in_isr", 64'(bus.in_isr), 64'h0);

    // call stack overflow then underflow
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.op    = OP_CALL;
    for (int i = 0; i < 9; i++) begin
      bus.target = 32'h500 + 32'(i);
      step();
    end
    check("ovf depth", 64'(bus.call_depth), 64'h8);
    check("ovf flag", 64'(bus.stack_overflow), 64'h1);
    check("ovf pc", 64'(bus.pc), 64'h508);
    bus.op = OP_RET;
    step();
    check("ret top pc", 64'(bus.pc), 64'h507);
    for (int i = 0; i < 7; i++) step();
    check("ret bottom pc", 64'(bus.pc), 64'h1);
    check("ret bottom depth", 64'(bus.call_depth), 64'h0);
    check("pre-udf flag", 64'(bus.stack_underflow), 64'h0);
    step();
    check("udf pc", 64'(bus.pc), 64'h1);
    check("udf flag", 64'(bus.stack_underflow), 64'h1);
    check("udf keeps ovf", 64'(bus.stack_overflow), 64'h1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start clr ovf", 64'(bus.stack_overflow), 64'h0);
    check("start clr udf", 64'(bus.stack_underflow), 64'h0);
    check("start pc", 64'(bus.pc), 64'h0);

    // branch wrap, masking, interrupt beats op
    bus.op = OP_JUMP; bus.target = 32'h2;
    step();
    bus.op = OP_BRANCH; bus.target = 32'hFFFF_FFFD;
    step();
    check("branch wrap pc", 64'(bus.pc), 64'hFFFF_FFFF);
    bus.op = OP_HOLD; bus.irq = 4'b0010; bus.irq_enable = 1'b0;
    step();
    check("masked pc", 64'(bus.pc), 64'hFFFF_FFFF);
    check("masked ack", 64'(bus.irq_ack), 64'h0);
    bus.op = OP_JUMP; bus.target = 32'h777; bus.irq = 4'b0100; bus.irq_enable = 1'b1;
    step();
    check("irq2 over jump pc", 64'(bus.pc), 64'h180);
    check("irq2 ack", 64'(bus.irq_ack), 64'h4);
    bus.op = OP_HOLD; bus.irq = 4'b0010;
    step();
    check("in_isr blocks pc", 64'(bus.pc), 64'h180);
    check("in_isr blocks ack", 64'(bus.irq_ack), 64'h0);
    bus.irq = 4'b0000; bus.op = OP_CALL; bus.target = 32'h900;
    step();
    check("pre-reset depth", 64'(bus.call_depth), 64'h1);

    // asynchronous reset while a CALL is pending
    bus.target = 32'hA00;
    #2 reset = 1'b1;
    #1;
    check_reset_state("async reset");
    #3 reset = 1'b0;
    bus.op = OP_HOLD;
    step();
    check("post-reset pc", 64'(bus.pc), 64'h0);
    check("post-reset depth", 64'(bus.call_depth), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer. It drives the instruction-memory address bus from decoded control ops, interrupt requests and fetch handshakes. It keeps separate function-call and interrupt return stacks of configurable depth, a configurable number of prioritised interrupt vectors, and sticky stack-fault flags. It sits between the decode/control unit and instruction memory, and is the successor to the fixed 32-bit, three-interrupt PC.

## Interface
- ADDR_W, 32, address width
- STACK_DEPTH, 8, entries per return stack (power of two, ≥2)
- NUM_IRQ, 4, interrupt lines; line 0 is non-maskable
- VEC_BASE, 'h80, vector of line 0
- VEC_STRIDE, 'h80, spacing between consecutive vectors

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  synchronous restart to address 0
- op  in  3  control op (encodings in pc_pkg)
- target  in  ADDR_W  jump/call target, or branch offset (two's complement)
- fetch_complete  in  1  current instruction fetched
- irq  in  NUM_IRQ  level interrupt requests
- irq_enable  in  1  global enable for lines 1..NUM_IRQ-1
- pc  out  ADDR_W  instruction-memory address
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge of the taken line
- in_isr  out  1  ISR stack non-empty
- call_depth  out  $clog2(STACK_DEPTH)+1  call stack occupancy
- isr_depth  out  $clog2(STACK_DEPTH)+1  ISR stack occupancy
- stack_overflow  out  1  sticky: push attempted on a full stack
- stack_underflow  out  1  sticky: pop attempted on an empty stack

## Operation
- Priority per cycle: reset > start > interrupt > op. A cycle that takes an interrupt discards op; the control unit re-issues it.
- Interrupt eligibility:
  - Line 0 is always eligible and nests.
  - Lines ≥1 are eligible only when irq_enable=1 and isr_depth=0.
  - Among eligible lines, the lowest index wins.
- Taking interrupt i:
  - Push the return address onto the ISR stack: pc+1 if fetch_complete, else pc.
  - pc ← VEC_BASE + i·VEC_STRIDE.
  - irq_ack[i] pulses.
- Ops:
  - NEXT: pc+1 if fetch_complete, else hold.
  - HOLD: hold. Covers NOP, stall and halt.
  - JUMP: pc ← target.
  - BRANCH: pc ← pc + target.
  - CALL: push pc+1 onto the call stack; pc ← target.
  - RET: pop the call stack into pc.
  - RETI: pop the ISR stack into pc.
  - FLUSH: pc ← 0. Stacks are untouched.
- Push on a full stack: no write, depth unchanged, stack_overflow ← 1. The redirect still occurs.
- Pop on an empty stack: pc holds, depth unchanged, stack_underflow ← 1.
- Arithmetic is modulo 2^ADDR_W. Wrap-around is silent.
- start: pc ← 0, both depths ← 0, both fault flags cleared, irq_ack ← 0. An irq asserted in the same cycle is ignored.

## Timing
- Reset values: pc=0, irq_ack=0, in_isr=0, call_depth=0, isr_depth=0, stack_overflow=0, stack_underflow=0. Stack contents are undefined.
- Every decision is sampled on the rising edge. The new pc is visible one cycle later, with no combinational path from inputs to outputs.
- irq_ack is registered and high in the same cycle that pc shows the vector.
- Occupancy, in_isr and fault flags update on the same edge as pc.
- irq is level-sensitive: the source must deassert after irq_ack. A held maskable line is blocked by in_isr. A held line 0 re-enters every cycle, and is the source's responsibility.
- Asynchronous reset mid-operation abandons any push or pop. After release the outputs equal the reset values.

## Structure
- pc_pkg holds:
  - op encodings: NEXT=0, HOLD=1, JUMP=2, BRANCH=3, CALL=4, RET=5, RETI=6, FLUSH=7.
  - A function computing the vector address from index, VEC_BASE and VEC_STRIDE.
- Sub-module return_stack (LIFO):
  - Parameters: width, depth.
  - Ports: push/pop, data in/out, depth, full/empty.
  - Instantiated twice, once for the call stack and once for the ISR stack.
- The top level holds the priority encoder, next-pc mux and fault flags.

## Test plan
- Reset, then start, then NEXT with fetch_complete=1 for 3 cycles -> pc=0,1,2,3. With fetch_complete=0 -> pc holds.
- pc=0x10, CALL target=0x400 -> pc=0x400, call_depth=1. RET -> pc=0x11, call_depth=0.
- pc=0x20, irq=4'b0110, irq_enable=1, fetch_complete=1 -> pc=0x100, irq_ack=4'b0010, in_isr=1. Then irq[0] pulse -> pc=0x80, isr_depth=2. Two RETI -> pc=0x101, then 0x21.
- CALL issued 9 times with STACK_DEPTH=8 -> call_depth saturates at 8, stack_overflow=1, pc=target. RET on empty stack -> pc holds, stack_underflow=1. start clears both flags.
- pc=0x2, BRANCH target=-3 -> pc=2^ADDR_W-1. JUMP in the same cycle as an eligible irq[2] -> pc=0x180 and the JUMP is dropped.
- reset asserted mid-CALL -> all outputs at reset values on the next observation, with no clock edge required.
